ram_arbiter: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 19 +
 rtl/ram_arbiter.sv | 138 +++++++++++++
 tb/tb_ram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-port RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Stateless 2-way round-robin picker; bit 0 is cpu, bit 1 is dbg.
// 'last' is 1 when dbg held the previous grant.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // A lone requester wins outright; on a tie the side not granted last wins.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and 3-cycle sequencer sharing one RAM port between
// the cpu datapath and the debug/program-loader port.
// Optional feature: define RAM_ARB_WPROT_EN to block dbg writes below PROT_TOP.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_DATA_W,
    parameter logic [ADDR_W-1:0] PROT_TOP = ADDR_W'(16)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_done,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_err,
    output logic              write_enable,
    output logic              ram_read,
    output logic [ADDR_W-1:0] access_address,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] data_out
);

`ifdef RAM_ARB_WPROT_EN
    localparam bit WPROT_ON = 1'b1;
`else
    localparam bit WPROT_ON = 1'b0;
`endif

    arb_state_t        state;
    arb_state_t        next_state;
    req_id_t           last_gnt;
    req_id_t           lat_id;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        pick;
    logic              accept;
    logic              blocked;

    rr_arb2 u_pick (
        .req  ({dbg_req, cpu_req}),
        .last (last_gnt == REQ_DBG),
        .gnt  (pick)
    );

    // A latched dbg write into the protected low region is suppressed.
    assign blocked = WPROT_ON && (lat_id == REQ_DBG) && lat_we && (lat_addr < PROT_TOP);

    assign cpu_rdata = cpu_done ? rdata_q : '0;
    assign dbg_rdata = dbg_done ? rdata_q : '0;

    // State register; reset drops straight back to IDLE, abandoning any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and all handshake/RAM outputs, decoded from the current state.
    always_comb begin
        next_state     = state;
        accept         = 1'b0;
        cpu_gnt        = 1'b0;
        dbg_gnt        = 1'b0;
        cpu_done       = 1'b0;
        dbg_done       = 1'b0;
        dbg_err        = 1'b0;
        write_enable   = 1'b0;
        ram_read       = 1'b0;
        access_address = '0;
        write_data     = '0;
        case (state)
            IDLE: begin
                cpu_gnt = pick[0];
                dbg_gnt = pick[1];
                accept  = |pick;
                if (accept) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                write_enable   = lat_we & ~blocked;
                ram_read       = ~lat_we;
                access_address = lat_addr;
                write_data     = lat_wdata;
                next_state     = DONE;
            end
            DONE: begin
                cpu_done   = (lat_id == REQ_CPU);
                dbg_done   = (lat_id == REQ_DBG);
                dbg_err    = (lat_id == REQ_DBG) & blocked;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command latches, round-robin history and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt  <= REQ_DBG;
            lat_id    <= REQ_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            if (accept) begin
                lat_id    <= pick[1] ? REQ_DBG : REQ_CPU;
                last_gnt  <= pick[1] ? REQ_DBG : REQ_CPU;
                lat_we    <= pick[1] ? dbg_we : cpu_we;
                lat_addr  <= pick[1] ? dbg_addr : cpu_addr;
                lat_wdata <= pick[1] ? dbg_wdata : cpu_wdata;
            end
            if (state == ACCESS) begin
                rdata_q <= lat_we ? '0 : data_out;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, cycle-level reference model with a
// per-cycle compare, and directed transactions with literal expectations.
module tb_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [7:0]  cpu_addr, dbg_addr;
    logic [15:0] cpu_wdata, dbg_wdata;
    logic        cpu_gnt, cpu_done, dbg_gnt, dbg_done, dbg_err;
    logic [15:0] cpu_rdata, dbg_rdata;
    logic        write_enable, ram_read;
    logic [7:0]  access_address;
    logic [15:0] write_data, data_out;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    ram_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_gnt        (cpu_gnt),
        .cpu_done       (cpu_done),
        .cpu_rdata      (cpu_rdata),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_gnt        (dbg_gnt),
        .dbg_done       (dbg_done),
        .dbg_rdata      (dbg_rdata),
        .dbg_err        (dbg_err),
        .write_enable   (write_enable),
        .ram_read       (ram_read),
        .access_address (access_address),
        .write_data     (write_data),
        .data_out       (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to timestamp observed grants and completions.
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with combinational read; contents start as 16'h1000 + address.
    logic [15:0] ram [256];
    bit ram_loaded = 1'b0;
    assign data_out = ram[access_address];
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'(16'h1000 + i);
            ram_loaded <= 1'b1;
        end else if (write_enable) begin
            ram[access_address] <= write_data;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observation logs filled by the compare process.
    int          gnt_cyc[$];
    bit          gnt_id[$];
    int          done_cyc[$];
    bit          done_id[$];
    logic [15:0] done_rd[$];
    bit          done_err[$];

    // Reference model: phase 0 idle, 1 RAM access, 2 completion.
    int          m_phase = 0;
    bit          m_last = 1'b1;
    bit          m_owner, m_we, m_blk, m_err;
    logic [7:0]  m_addr;
    logic [15:0] m_wd, m_rd;
    logic [15:0] ref_mem [256];
    bit          model_loaded = 1'b0;
    logic        e_cg, e_dg, e_cd, e_dd, e_we, e_rr;
    logic [7:0]  e_a;
    logic [15:0] e_wd;

    // Compare every cycle against the model, log events, then advance the model.
    always @(negedge clk) begin
        if (!model_loaded) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = 16'(16'h1000 + i);
            model_loaded = 1'b1;
        end
        e_cg = 0; e_dg = 0; e_cd = 0; e_dd = 0; e_we = 0; e_rr = 0; e_a = '0; e_wd = '0;
        m_blk = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            m_last  = 1'b1;
        end else if (m_phase == 0) begin
            e_cg = cpu_req && (!dbg_req || m_last);
            e_dg = dbg_req && (!cpu_req || !m_last);
        end else if (m_phase == 1) begin
`ifdef RAM_ARB_WPROT_EN
            m_blk = m_owner && m_we && (m_addr < 8'h10);
`else
            m_blk = 1'b0;
`endif
            e_we = m_we && !m_blk;
            e_rr = !m_we;
            e_a  = m_addr;
            e_wd = m_wd;
        end else begin
            e_cd = !m_owner;
            e_dd = m_owner;
        end
        checkOutput("cpu_gnt", cpu_gnt, e_cg);
        checkOutput("dbg_gnt", dbg_gnt, e_dg);
        checkOutput("cpu_done", cpu_done, e_cd);
        checkOutput("dbg_done", dbg_done, e_dd);
        checkOutput("dbg_err", dbg_err, e_dd && m_err);
        checkOutput("write_enable", write_enable, e_we);
        checkOutput("ram_read", ram_read, e_rr);
        checkOutput("access_address", access_address, e_a);
        checkOutput("write_data", write_data, e_wd);
        if (e_cd) checkOutput("cpu_rdata", cpu_rdata, m_rd);
        if (e_dd) checkOutput("dbg_rdata", dbg_rdata, m_rd);

        if (cpu_gnt === 1'b1) begin gnt_cyc.push_back(cyc); gnt_id.push_back(1'b0); end
        if (dbg_gnt === 1'b1) begin gnt_cyc.push_back(cyc); gnt_id.push_back(1'b1); end
        if (cpu_done === 1'b1) begin
            done_cyc.push_back(cyc); done_id.push_back(1'b0);
            done_rd.push_back(cpu_rdata); done_err.push_back(1'b0);
        end
        if (dbg_done === 1'b1) begin
            done_cyc.push_back(cyc); done_id.push_back(1'b1);
            done_rd.push_back(dbg_rdata); done_err.push_back(dbg_err);
        end

        if (rst_n) begin
            if (m_phase == 0) begin
                if (e_cg || e_dg) begin
                    m_owner = e_dg;
                    m_last  = e_dg;
                    m_we    = e_dg ? dbg_we : cpu_we;
                    m_addr  = e_dg ? dbg_addr : cpu_addr;
                    m_wd    = e_dg ? dbg_wdata : cpu_wdata;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_rd  = m_we ? 16'h0000 : ref_mem[m_addr];
                m_err = m_blk;
                if (m_we && !m_blk) ref_mem[m_addr] = m_wd;
                m_phase = 2;
            end else begin
                m_phase = 0;
            end
        end
    end

    task automatic applyStimulus(input logic c_req, input logic c_we, input logic [7:0] c_addr,
                                 input logic [15:0] c_wd, input logic d_req, input logic d_we,
                                 input logic [7:0] d_addr, input logic [15:0] d_wd);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dbg_req = d_req; dbg_we = d_we; dbg_addr = d_addr; dbg_wdata = d_wd;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One transaction on one port; returns captured rdata/err from the done cycle.
    task automatic runTxn(input bit port, input logic we, input logic [7:0] addr,
                          input logic [15:0] wd, output logic [15:0] rd, output logic err);
        int bg, bd, n;
        bg = gnt_id.size(); bd = done_id.size(); rd = '0; err = 1'b0;
        if (port) applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, we, addr, wd);
        else      applyStimulus(1'b1, we, addr, wd, 1'b0, 1'b0, 8'h00, 16'h0000);
        n = 0;
        while (gnt_id.size() == bg && n < 20) begin @(negedge clk); #1; n++; end
        if (gnt_id.size() == bg) begin
            checkOutput("txn_gnt_timeout", 32'd0, 32'd1);
            idleInputs();
            return;
        end
        @(posedge clk); #1;
        idleInputs();
        n = 0;
        while (done_id.size() == bd && n < 6) begin @(negedge clk); #1; n++; end
        if (done_id.size() == bd) begin
            checkOutput("txn_done_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("txn_gnt_id", gnt_id[bg], port);
        checkOutput("txn_done_id", done_id[bd], port);
        checkOutput("txn_done_latency", done_cyc[bd] - gnt_cyc[bg], 32'd2);
        rd  = done_rd[bd];
        err = done_err[bd];
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rd;
        logic        err;
        int          bg, bd, n;
        bit          exp_order [6];
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b1;
        idleInputs();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // cpu write then read back
        runTxn(1'b0, 1'b1, 8'h20, 16'hBEEF, rd, err);
        checkOutput("t1_write_rdata_zero", rd, 16'h0000);
        runTxn(1'b0, 1'b0, 8'h20, 16'h0000, rd, err);
        checkOutput("t1_cpu_rdata", rd, 16'hBEEF);

        // both ports requesting continuously: strict alternation starting with cpu
        resetDut();
        @(posedge clk); #1;
        bg = gnt_id.size(); bd = done_id.size();
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0000, 1'b1, 1'b0, 8'h21, 16'h0000);
        n = 0;
        while (gnt_id.size() < bg + 6 && n < 60) begin @(negedge clk); #1; n++; end
        if (gnt_id.size() < bg + 6) checkOutput("t2_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        idleInputs();
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 6; k++) begin
            if (gnt_id.size() > bg + k && done_id.size() > bd + k) begin
                checkOutput($sformatf("t2_gnt_order%0d", k), gnt_id[bg + k], exp_order[k]);
                checkOutput($sformatf("t2_done_id%0d", k), done_id[bd + k], exp_order[k]);
                checkOutput($sformatf("t2_latency%0d", k), done_cyc[bd + k] - gnt_cyc[bg + k], 32'd2);
            end else begin
                checkOutput($sformatf("t2_missing%0d", k), 32'd0, 32'd1);
            end
        end

        // cpu drops its request during ACCESS as dbg raises one
        bg = gnt_id.size();
        applyStimulus(1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000);
        n = 0;
        while (gnt_id.size() == bg && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h21, 16'h0000);
        n = 0;
        while (gnt_id.size() < bg + 2 && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        idleInputs();
        repeat (3) @(posedge clk);
        #1;
        if (gnt_id.size() == bg + 2) begin
            checkOutput("t3_first_cpu", gnt_id[bg], 1'b0);
            checkOutput("t3_then_dbg", gnt_id[bg + 1], 1'b1);
            checkOutput("t3_dbg_gnt_gap", gnt_cyc[bg + 1] - gnt_cyc[bg], 32'd3);
        end else begin
            checkOutput("t3_gnt_count", gnt_id.size() - bg, 32'd2);
        end

        // reset during the ACCESS cycle of a dbg write
        bd = done_id.size(); bg = gnt_id.size();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h40, 16'h1234);
        n = 0;
        while (gnt_id.size() == bg && n < 20) begin @(negedge clk); #1; n++; end
        @(posedge clk); #1;
        idleInputs();
        checkOutput("t4_we_in_access", write_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t4_rst_we", write_enable, 1'b0);
        checkOutput("t4_rst_rd", ram_read, 1'b0);
        checkOutput("t4_rst_addr", access_address, 8'h00);
        checkOutput("t4_rst_wdata", write_data, 16'h0000);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t4_no_dbg_done", done_id.size() - bd, 32'd0);
        runTxn(1'b0, 1'b0, 8'h40, 16'h0000, rd, err);
        checkOutput("t4_old_value", rd, 16'h1040);

        // dbg write into the low region
        runTxn(1'b1, 1'b1, 8'h05, 16'hFFFF, rd, err);
`ifdef RAM_ARB_WPROT_EN
        checkOutput("t5_blocked_err", err, 1'b1);
        runTxn(1'b0, 1'b0, 8'h05, 16'h0000, rd, err);
        checkOutput("t5_prot_readback", rd, 16'h1005);
        runTxn(1'b1, 1'b1, 8'h10, 16'h5A5A, rd, err);
        checkOutput("t5_unprot_err", err, 1'b0);
        runTxn(1'b0, 1'b0, 8'h10, 16'h0000, rd, err);
        checkOutput("t5_unprot_readback", rd, 16'h5A5A);
`else
        checkOutput("t5_err_zero", err, 1'b0);
        runTxn(1'b0, 1'b0, 8'h05, 16'h0000, rd, err);
        checkOutput("t5_readback", rd, 16'hFFFF);
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
